// File: rtl/mips_reg_dump.sv
// Debug reader that walks the register file through one read port and streams each word out on valid/ready.
// Optional build macro REG_DUMP_SKIP_ZERO_EN: skip hardwired register 0 and start the walk at index 1.
module mips_reg_dump #(
   parameter int unsigned NUM_REGS = 32,
   parameter int unsigned ADDR_W   = 5,
   parameter int unsigned DATA_W   = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   output logic [ADDR_W-1:0] read_reg,
   input  logic [DATA_W-1:0] read_data,
   output logic              dump_valid,
   input  logic              dump_ready,
   output logic [DATA_W-1:0] dump_data,
   output logic [ADDR_W-1:0] dump_index,
   output logic              dump_busy,
   output logic              dump_done
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_READ = 2'd1;
   localparam logic [1:0] S_SEND = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

`ifdef REG_DUMP_SKIP_ZERO_EN
   localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(1);
`else
   localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(0);
`endif
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

   logic [1:0]        state, state_n;
   logic [ADDR_W-1:0] idx, idx_n;
   logic              valid_n, busy_n, done_n;
   logic [DATA_W-1:0] data_n;
   logic [ADDR_W-1:0] index_n;

   // The read port follows the walk counter directly so read_data is ready in READ.
   assign read_reg = idx;

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         idx        <= '0;
         dump_valid <= 1'b0;
         dump_data  <= '0;
         dump_index <= '0;
         dump_busy  <= 1'b0;
         dump_done  <= 1'b0;
      end else begin
         state      <= state_n;
         idx        <= idx_n;
         dump_valid <= valid_n;
         dump_data  <= data_n;
         dump_index <= index_n;
         dump_busy  <= busy_n;
         dump_done  <= done_n;
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_n = state;
      idx_n   = idx;
      valid_n = dump_valid;
      data_n  = dump_data;
      index_n = dump_index;
      busy_n  = dump_busy;
      done_n  = 1'b0;

      case (state)
         S_IDLE: begin
            if (start && !abort) begin
               idx_n   = FIRST_IDX;
               busy_n  = 1'b1;
               state_n = S_READ;
            end
         end
         S_READ: begin
            if (abort) begin
               valid_n = 1'b0;
               busy_n  = 1'b0;
               state_n = S_IDLE;
            end else begin
               data_n  = read_data;
               index_n = idx;
               valid_n = 1'b1;
               state_n = S_SEND;
            end
         end
         S_SEND: begin
            // Abort wins over a same-cycle handshake; that word is not delivered.
            if (abort) begin
               valid_n = 1'b0;
               busy_n  = 1'b0;
               state_n = S_IDLE;
            end else if (dump_ready) begin
               valid_n = 1'b0;
               if (idx == LAST_IDX) begin
                  done_n  = 1'b1;
                  state_n = S_DONE;
               end else begin
                  idx_n   = idx + ADDR_W'(1);
                  state_n = S_READ;
               end
            end
         end
         S_DONE: begin
            busy_n  = 1'b0;
            state_n = S_IDLE;
         end
         default: begin
            valid_n = 1'b0;
            busy_n  = 1'b0;
            state_n = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_mips_reg_dump.sv
// Directed bench for mips_reg_dump with a preloaded register-file model (reg[i] = A000_0000 + i).
module tb_mips_reg_dump;

   localparam int unsigned NUM_REGS = 32;
   localparam int unsigned ADDR_W   = 5;
   localparam int unsigned DATA_W   = 32;
`ifdef REG_DUMP_SKIP_ZERO_EN
   localparam int FIRST = 1;
`else
   localparam int FIRST = 0;
`endif
   localparam int WORDS = NUM_REGS - FIRST;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              start;
   logic              abort;
   logic [ADDR_W-1:0] read_reg;
   logic [DATA_W-1:0] read_data;
   logic              dump_valid;
   logic              dump_ready;
   logic [DATA_W-1:0] dump_data;
   logic [ADDR_W-1:0] dump_index;
   logic              dump_busy;
   logic              dump_done;

   logic [DATA_W-1:0] rf [NUM_REGS];

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   assign read_data = rf[read_reg];

   mips_reg_dump #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .abort      (abort),
      .read_reg   (read_reg),
      .read_data  (read_data),
      .dump_valid (dump_valid),
      .dump_ready (dump_ready),
      .dump_data  (dump_data),
      .dump_index (dump_index),
      .dump_busy  (dump_busy),
      .dump_done  (dump_done)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Full dump from IDLE; optional stall on one word and optional stray start pulses.
   task automatic do_dump(input string tag, input int stall_idx, input int stall_len, input bit poke_start);
      int exp_idx    = FIRST;
      int words      = 0;
      int dones      = 0;
      int done_edge  = -1;
      int idle_edge  = -1;
      int stall_left = stall_len;
      start      = 1'b1;
      dump_ready = 1'b1;
      tick();
      start = 1'b0;
      check({tag, "_busy_after_start"}, 64'(dump_busy), 64'd1);
      check({tag, "_valid_in_read"}, 64'(dump_valid), 64'd0);
      for (int e = 1; e < 400 && idle_edge < 0; e++) begin
         if (dump_valid && int'(dump_index) == stall_idx && stall_left > 0) begin
            dump_ready = 1'b0;
            stall_left--;
            check({tag, "_stall_data"}, 64'(dump_data), 64'(32'hA000_0000 + 32'(stall_idx)));
            check({tag, "_stall_index"}, 64'(dump_index), 64'(stall_idx));
         end else begin
            dump_ready = 1'b1;
         end
         if (poke_start) start = (e % 7 == 3);
         if (dump_valid && dump_ready) begin
            check({tag, "_word_index"}, 64'(dump_index), 64'(exp_idx));
            check({tag, "_word_data"}, 64'(dump_data), 64'(32'hA000_0000 + 32'(exp_idx)));
            exp_idx++;
            words++;
         end
         tick();
         if (dump_done) begin
            dones++;
            done_edge = e;
         end
         if (!dump_busy) idle_edge = e;
      end
      start      = 1'b0;
      dump_ready = 1'b1;
      check({tag, "_terminated"}, 64'(idle_edge >= 0), 64'd1);
      check({tag, "_word_count"}, 64'(words), 64'(WORDS));
      check({tag, "_done_count"}, 64'(dones), 64'd1);
      check({tag, "_done_edge"}, 64'(done_edge), 64'(2 * WORDS + stall_len));
      check({tag, "_busy_drop_edge"}, 64'(idle_edge), 64'(2 * WORDS + stall_len + 1));
      check({tag, "_valid_idle"}, 64'(dump_valid), 64'd0);
   endtask

   // Run a dump with ready high until the word for index target is presented.
   task automatic run_to_index(input string tag, input int target);
      bit found = 1'b0;
      start      = 1'b1;
      dump_ready = 1'b1;
      tick();
      start = 1'b0;
      for (int e = 0; e < 200 && !found; e++) begin
         if (dump_valid && int'(dump_index) == target) begin
            found = 1'b1;
         end else begin
            tick();
         end
      end
      check({tag, "_reached_index"}, 64'(found), 64'd1);
   endtask

   initial begin
      int dones;
      for (int i = 0; i < int'(NUM_REGS); i++) rf[i] = 32'hA000_0000 + 32'(i);
      rst_n      = 1'b0;
      start      = 1'b0;
      abort      = 1'b0;
      dump_ready = 1'b0;
      #12;
      check("reset_read_reg", 64'(read_reg), 64'd0);
      check("reset_valid", 64'(dump_valid), 64'd0);
      check("reset_data", 64'(dump_data), 64'd0);
      check("reset_index", 64'(dump_index), 64'd0);
      check("reset_busy", 64'(dump_busy), 64'd0);
      check("reset_done", 64'(dump_done), 64'd0);
      rst_n = 1'b1;
      tick();
      tick();

      do_dump("basic", -1, 0, 1'b0);
      tick();

      do_dump("stall", 7, 5, 1'b0);
      tick();

      // Abort while word 12 is presented, with ready high in the same cycle.
      run_to_index("abort", 12);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort_valid", 64'(dump_valid), 64'd0);
      check("abort_busy", 64'(dump_busy), 64'd0);
      dones = int'(dump_done);
      for (int i = 0; i < 4; i++) begin
         tick();
         dones += int'(dump_done);
      end
      check("abort_no_done", 64'(dones), 64'd0);
      check("abort_stays_idle", 64'(dump_busy), 64'd0);
      do_dump("after_abort", -1, 0, 1'b0);
      tick();

      // Asynchronous reset between edges while word 20 is presented.
      run_to_index("areset", 20);
      #2;
      rst_n = 1'b0;
      #1;
      check("areset_read_reg", 64'(read_reg), 64'd0);
      check("areset_valid", 64'(dump_valid), 64'd0);
      check("areset_data", 64'(dump_data), 64'd0);
      check("areset_index", 64'(dump_index), 64'd0);
      check("areset_busy", 64'(dump_busy), 64'd0);
      check("areset_done", 64'(dump_done), 64'd0);
      tick();
      #2;
      rst_n = 1'b1;
      tick();
      do_dump("after_reset", -1, 0, 1'b0);
      tick();

      do_dump("start_while_busy", -1, 0, 1'b1);
      tick();

      // start and abort together in IDLE: abort wins.
      start = 1'b1;
      abort = 1'b1;
      tick();
      start = 1'b0;
      abort = 1'b0;
      check("start_abort_busy", 64'(dump_busy), 64'd0);
      tick();
      check("start_abort_valid", 64'(dump_valid), 64'd0);
      check("start_abort_idle", 64'(dump_busy), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
